// File: rtl/ddr4_v2_2_24_tg_addr_prbs_gen.sv
// Traffic-generator address source: PRBS / increment / fixed pattern expanded into
// N_ENTRY mapped addresses per beat, with sequence-wrap detection and period counting.
`timescale 1ns/1ps
module ddr4_v2_2_24_tg_addr_prbs_gen #(
  parameter int TCQ        = 100,
  parameter int PRBS_WIDTH = 23,
  parameter int N_ENTRY    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_ALIGN = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_load,
  input  logic [1:0]                    cfg_mode,
  input  logic [PRBS_WIDTH-1:0]         cfg_seed,
  input  logic [PRBS_WIDTH-1:0]         cfg_taps,
  input  logic [PRBS_WIDTH-1:0]         cfg_mask,
  input  logic [ADDR_WIDTH-1:0]         cfg_base,
  output logic                          addr_valid,
  input  logic                          addr_ready,
  output logic [N_ENTRY*ADDR_WIDTH-1:0] addr_out,
  output logic                          prbs_repeat,
  output logic [31:0]                   period_cnt
);

  localparam int W  = PRBS_WIDTH;
  localparam int XW = ((W > ADDR_WIDTH) ? W : ADDR_WIDTH) + ADDR_ALIGN;

  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_FIXED = 2'd2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [1:0]            mode_p0;
  logic [W-1:0]          seed_p0;
  logic [W-1:0]          taps_p0;
  logic [W-1:0]          mask_p0;
  logic [ADDR_WIDTH-1:0] base_p0;
  logic [W-1:0]          pat_p0;
  logic                  first_p0;

  logic [W-1:0] ent [N_ENTRY+1];
  logic [W-1:0] seed_eff;
  logic         hit;
  logic         accept;

  // Registers carry no modelled clock-to-Q; TCQ only matters to delay-annotated models.
  logic tcq_unused;
  assign tcq_unused = ^TCQ;

  function automatic logic [W-1:0] prbs_step(input logic [W-1:0] cur,
                                             input logic [W-1:0] taps);
    return {cur[W-2:0], ^(cur & taps)};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [W-1:0]          e,
                                                     input logic [W-1:0]          mask,
                                                     input logic [ADDR_WIDTH-1:0] base);
    logic [XW-1:0] wide;
    wide = XW'(e & mask) << ADDR_ALIGN;
    return base + wide[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // An all-zero seed would lock the LFSR, so PRBS modes start from 1 instead.
  always_comb begin
    seed_eff = cfg_seed;
    if (cfg_seed == '0 && cfg_mode != MODE_INC && cfg_mode != MODE_FIXED)
      seed_eff = W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_load) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_valid = (state == RUN);
  end

  assign accept = addr_valid & addr_ready & ~cfg_load;

  // ent[N_ENTRY] is one past the last emitted entry: the next pattern in every mode.
  always_comb begin
    logic [W-1:0] cur;
    cur = pat_p0;
    for (int i = 0; i <= N_ENTRY; i++) begin
      ent[i] = cur;
      if (mode_p0 == MODE_INC)
        cur = cur + W'(1);
      else if (mode_p0 != MODE_FIXED)
        cur = prbs_step(cur, taps_p0);
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (ent[i] == seed_p0 && !(i == 0 && first_p0))
        hit = 1'b1;
    end
    if (mode_p0 == MODE_FIXED)
      hit = 1'b0;
  end

  always_comb begin
    addr_out = '0;
    for (int i = 0; i < N_ENTRY; i++)
      addr_out[i*ADDR_WIDTH +: ADDR_WIDTH] = map_addr(ent[i], mask_p0, base_p0);
  end

  // p0: configuration and pattern state; a load wins over a same-edge handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0  <= '0;
      seed_p0  <= '0;
      taps_p0  <= '0;
      mask_p0  <= '0;
      base_p0  <= '0;
      pat_p0   <= '0;
      first_p0 <= 1'b0;
    end else if (cfg_load) begin
      mode_p0  <= cfg_mode;
      seed_p0  <= seed_eff;
      taps_p0  <= cfg_taps;
      mask_p0  <= cfg_mask;
      base_p0  <= cfg_base;
      pat_p0   <= seed_eff;
      first_p0 <= 1'b1;
    end else if (accept) begin
      pat_p0   <= ent[N_ENTRY];
      first_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prbs_repeat <= 1'b0;
      period_cnt  <= '0;
    end else if (cfg_load) begin
      prbs_repeat <= 1'b0;
      period_cnt  <= '0;
    end else if (accept && !prbs_repeat) begin
      period_cnt  <= sat_inc(period_cnt);
      prbs_repeat <= hit;
    end
  end

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_addr_prbs_gen.sv
// Scoreboarded bench for the address pattern generator (W=8, 4 entries, 16-bit addresses),
// with a second instance at ADDR_ALIGN=3 for the shifted-mapping cases.
`timescale 1ns/1ps
module tb_ddr4_v2_2_24_tg_addr_prbs_gen;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_load;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_seed;
  logic [W-1:0]  cfg_taps;
  logic [W-1:0]  cfg_mask;
  logic [AW-1:0] cfg_base;
  logic          addr_ready;

  logic          addr_valid,   addr_valid_a;
  logic [N*AW-1:0] addr_out,   addr_out_a;
  logic          prbs_repeat,  prbs_repeat_a;
  logic [31:0]   period_cnt,   period_cnt_a;

  logic [N*AW-1:0] sb_q [$];
  logic [N*AW-1:0] sb_exp;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ddr4_v2_2_24_tg_addr_prbs_gen #(
    .TCQ(100), .PRBS_WIDTH(W), .N_ENTRY(N), .ADDR_WIDTH(AW), .ADDR_ALIGN(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_mask(cfg_mask), .cfg_base(cfg_base),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_out(addr_out),
    .prbs_repeat(prbs_repeat), .period_cnt(period_cnt)
  );

  ddr4_v2_2_24_tg_addr_prbs_gen #(
    .TCQ(100), .PRBS_WIDTH(W), .N_ENTRY(N), .ADDR_WIDTH(AW), .ADDR_ALIGN(3)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_mask(cfg_mask), .cfg_base(cfg_base),
    .addr_valid(addr_valid_a), .addr_ready(addr_ready), .addr_out(addr_out_a),
    .prbs_repeat(prbs_repeat_a), .period_cnt(period_cnt_a)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    return {8'h00, d, 8'h00, c, 8'h00, b, 8'h00, a};
  endfunction

  // Taps 0xB8 = bits 7,5,4,3
  function automatic logic [7:0] lfsr_b8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] mode, input logic [7:0] seed, input logic [7:0] taps,
                         input logic [7:0] mask, input logic [15:0] base);
    cfg_mode = mode;
    cfg_seed = seed;
    cfg_taps = taps;
    cfg_mask = mask;
    cfg_base = base;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Monitor: every accepted beat (not discarded by a coincident load) is checked in order.
  always @(negedge clk) begin
    if (rst_n && addr_valid && addr_ready && !cfg_load) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got beat %h, expected no beat", addr_out);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_beat", addr_out, sb_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mp, s1, s2, s3, b;

    rst_n = 1'b0; cfg_load = 1'b0; cfg_mode = 2'd0; cfg_seed = '0;
    cfg_taps = '0; cfg_mask = '0; cfg_base = '0; addr_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid",  addr_valid,  0);
    check("rst_addr",   addr_out,    0);
    check("rst_repeat", prbs_repeat, 0);
    check("rst_cnt",    period_cnt,  0);

    rst_n = 1'b1;
    addr_ready = 1'b1;
    repeat (3) tick();
    check("idle_ready_valid", addr_valid, 0);
    check("idle_ready_cnt",   period_cnt, 0);
    addr_ready = 1'b0;

    // PRBS wrap: period 255 entries -> seed recurs in beat 64
    sb_q.push_back(pack4(8'h01, 8'h02, 8'h04, 8'h08));
    sb_q.push_back(pack4(8'h11, 8'h23, 8'h47, 8'h8E));
    mp = 8'h1C;
    for (int k = 3; k <= 66; k++) begin
      s1 = lfsr_b8(mp);
      s2 = lfsr_b8(s1);
      s3 = lfsr_b8(s2);
      sb_q.push_back(pack4(mp, s1, s2, s3));
      mp = lfsr_b8(s3);
    end
    do_load(2'd0, 8'h01, 8'hB8, 8'hFF, 16'h0000);
    check("prbs_valid", addr_valid, 1);
    addr_ready = 1'b1;
    repeat (63) tick();
    check("prbs_rep_b63", prbs_repeat, 0);
    check("prbs_cnt_b63", period_cnt,  63);
    tick();
    check("prbs_rep_b64", prbs_repeat, 1);
    check("prbs_cnt_b64", period_cnt,  64);
    repeat (2) tick();
    check("prbs_rep_sticky", prbs_repeat, 1);
    check("prbs_cnt_frozen", period_cnt,  64);
    addr_ready = 1'b0;

    // Increment wrap from 0xFE, with 5 cycles of backpressure first
    sb_q.push_back(pack4(8'hFE, 8'hFF, 8'h00, 8'h01));
    sb_q.push_back(pack4(8'h02, 8'h03, 8'h04, 8'h05));
    b = 8'h06;
    for (int k = 3; k <= 65; k++) begin
      sb_q.push_back(pack4(b, b + 8'd1, b + 8'd2, b + 8'd3));
      b = b + 8'd4;
    end
    do_load(2'd1, 8'hFE, 8'hB8, 8'hFF, 16'h0000);
    check("load_clr_repeat", prbs_repeat, 0);
    check("load_clr_cnt",    period_cnt,  0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_addr", addr_out,   pack4(8'hFE, 8'hFF, 8'h00, 8'h01));
      check("bp_hold_cnt",  period_cnt, 0);
    end
    addr_ready = 1'b1;
    tick();
    check("bp_adv_cnt",  period_cnt, 1);
    check("bp_adv_addr", addr_out,   pack4(8'h02, 8'h03, 8'h04, 8'h05));
    repeat (63) tick();
    check("inc_rep_b64", prbs_repeat, 0);
    check("inc_cnt_b64", period_cnt,  64);
    tick();
    check("inc_rep_b65", prbs_repeat, 1);
    check("inc_cnt_b65", period_cnt,  65);
    addr_ready = 1'b0;

    // Zero seed in PRBS mode starts from 1
    do_load(2'd0, 8'h00, 8'hB8, 8'hFF, 16'h0000);
    check("lockup_addr", addr_out, pack4(8'h01, 8'h02, 8'h04, 8'h08));

    // Address mapping: (0x3A & 0x0F) = 0x0A; shifted by 3 -> 0x50
    do_load(2'd2, 8'h3A, 8'hB8, 8'h0F, 16'h1000);
    check("map_align0", addr_out,   {4{16'h100A}});
    check("map_align3", addr_out_a, {4{16'h1050}});
    repeat (4) sb_q.push_back({4{16'h100A}});
    addr_ready = 1'b1;
    repeat (4) tick();
    addr_ready = 1'b0;
    check("fixed_no_repeat",   prbs_repeat,   0);
    check("fixed_cnt",         period_cnt,    4);
    check("fixed_no_repeat_a", prbs_repeat_a, 0);
    check("fixed_cnt_a",       period_cnt_a,  4);

    do_load(2'd2, 8'h10, 8'hB8, 8'hFF, 16'hFFF8);
    check("base_wrap_align0", addr_out,   {4{16'h0008}});
    check("base_wrap_align3", addr_out_a, {4{16'h0078}});

    // Reload on the same edge as a handshake: that beat is dropped
    do_load(2'd1, 8'h10, 8'hB8, 8'hFF, 16'h0000);
    sb_q.push_back(pack4(8'h10, 8'h11, 8'h12, 8'h13));
    addr_ready = 1'b1;
    tick();
    check("reload_pre_cnt", period_cnt, 1);
    cfg_seed = 8'h40;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    addr_ready = 1'b0;
    check("reload_cnt",  period_cnt, 0);
    check("reload_addr", addr_out,   pack4(8'h40, 8'h41, 8'h42, 8'h43));
    sb_q.push_back(pack4(8'h40, 8'h41, 8'h42, 8'h43));
    sb_q.push_back(pack4(8'h44, 8'h45, 8'h46, 8'h47));
    addr_ready = 1'b1;
    repeat (2) tick();
    addr_ready = 1'b0;
    check("reload_cnt2", period_cnt, 2);

    // Asynchronous reset mid-stream
    do_load(2'd1, 8'h20, 8'hB8, 8'hFF, 16'h0000);
    sb_q.push_back(pack4(8'h20, 8'h21, 8'h22, 8'h23));
    sb_q.push_back(pack4(8'h24, 8'h25, 8'h26, 8'h27));
    addr_ready = 1'b1;
    repeat (2) tick();
    addr_ready = 1'b0;
    check("mid_cnt", period_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",   addr_valid,   0);
    check("arst_addr",    addr_out,     0);
    check("arst_cnt",     period_cnt,   0);
    check("arst_repeat",  prbs_repeat,  0);
    check("arst_valid_a", addr_valid_a, 0);
    tick();
    rst_n = 1'b1;
    addr_ready = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", addr_valid, 0);
    addr_ready = 1'b0;

    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
